li_reg_port: RTL
================

# li_reg_port

Latency-insensitive register responder: the module side of the VALID/CONSUMED token protocol used by generated parent modules. Each model cycle it offers one read token (current value), accepts one write-data token and one write-enable token, then commits. Wall-clock cycles per model cycle vary with upstream and downstream readiness. Parents instantiate it wherever a plain register would sit and wire its ports like any other token-protocol module.

## Interface
- WIDTH, 32, data width of the register.
- INIT, 0, value loaded on reset (WIDTH bits).
- CLK  in  1  clock, all state on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- IN_WRITE  in  WIDTH  write-data token payload.
- IN_WRITE_VALID  in  1  write-data token present.
- IN_WRITE_CONSUMED  out  1  write-data token taken this clock.
- IN_EN_WRITE  in  1  write-enable token payload.
- IN_EN_WRITE_VALID  in  1  write-enable token present.
- IN_EN_WRITE_CONSUMED  out  1  write-enable token taken this clock.
- OUT_READ  out  WIDTH  read token payload, the current register value.
- OUT_READ_VALID  out  1  read token offered for the current model cycle.
- OUT_READ_CONSUMED  in  1  downstream took the read token this clock.
- MODEL_CYCLE  out  32  count of committed model cycles.

## Operation
- A token transfers on a clock where VALID and CONSUMED are both high.
- Internal state:
  - value register.
  - Three done flags: rd_done, wr_got, en_got.
  - Latched wr_data and en_data.
  - MODEL_CYCLE counter.
- The flags form the state machine (8 states). COLLECT means some flag is clear. COMMIT is the clock on which all three flags, counting same-clock transfers, become set.
- OUT_READ_VALID = !rd_done, registered. OUT_READ = value, stable through the whole model cycle.
- IN_WRITE_CONSUMED = IN_WRITE_VALID && !wr_got. The same form applies to IN_EN_WRITE_CONSUMED. These outputs depend only on their own VALID and on flags. There is no combinational path from OUT_READ_CONSUMED to any output.
- Read and write tokens are independent. The read token never waits for a write token; this is what breaks cyclic parent wiring such as two cross-coupled registers.
- COMMIT edge:
  - value <= (en_data ? wr_data : value), using same-clock payloads when they transfer on that edge.
  - All flags clear.
  - MODEL_CYCLE += 1, wrapping at 2^32.
- Tokens arriving after their flag is set are not consumed; they wait for the next model cycle.

## Timing
- Reset: value=INIT, flags clear, MODEL_CYCLE=0, OUT_READ_VALID=0, both IN_*_CONSUMED=0.
  - OUT_READ_VALID rises on the first clock after RST_N is released.
  - CONSUMED outputs are forced 0 while RST_N=0.
- Minimum model-cycle period: 1 clock, when all three tokens transfer on the same edge. OUT_READ_VALID then stays 1 and OUT_READ shows the new value the next clock.
- Write-to-read latency: one model cycle. A write committed in model cycle n is read in n+1.
- A stalled read (OUT_READ_CONSUMED held 0) holds OUT_READ and VALID unchanged indefinitely. Early write tokens are latched and held.
- Simultaneous events:
  - Read transfer plus final write transfer on the same edge → COMMIT.
  - A write arriving on the COMMIT edge for the next cycle is not taken; it is taken the clock after.
- Reset mid-model-cycle discards latched tokens and partial flags. There is no CONSUMED pulse during reset.
- en_data=0 at COMMIT: value unchanged, MODEL_CYCLE still increments.

## Structure
- Shared package li_pkg holds:
  - The token-transfer helper function (valid && consumed).
  - The MODEL_CYCLE width constant (32).
- Sub-module li_token_slot, instantiated twice (write data, write enable). Contents: done flag, payload latch, CONSUMED generation, clear-on-commit input.
- Read side and commit logic stay in the top.

## Test plan
- **Cross-coupled pair**: two instances with INIT=24 and INIT=45. Each one's OUT_READ drives the other's IN_WRITE, EN tied 1, VALID and CONSUMED wired as the parent does → per model cycle reads (24,45), (45,24), (24,45). MODEL_CYCLE increments every clock.
- **Read stall**: hold OUT_READ_CONSUMED=0 for 5 clocks with write tokens valid → wr/en CONSUMED pulse once, then stay 0. OUT_READ is constant. Commit happens on the clock the read transfers.
- **Write stall**: read consumed immediately, IN_WRITE_VALID delayed 3 clocks → OUT_READ_VALID=0 from the clock after the read, until COMMIT. The new value appears the clock after the write transfer.
- **Enable low**: INIT=7, write 99 with EN=0 → next read is 7 and MODEL_CYCLE has advanced by 1.
- **Reset mid-cycle**: write token latched, read not yet consumed, RST_N=0 for 1 clock → value=INIT, MODEL_CYCLE=0, OUT_READ_VALID=0 during reset and 1 after. The latched write is lost.
- **Counter wrap**: preload via a force to 0xFFFFFFFF, one commit → MODEL_CYCLE=0.

Source files
------------

// File: rtl/li_pkg.sv
// Shared definitions for the latency-insensitive token protocol.
package li_pkg;

    // Width of the committed model-cycle counter.
    localparam int MC_WIDTH = 32;

    // A token moves on any clock where it is offered and taken.
    function automatic logic xfer(input logic valid, input logic consumed);
        return valid && consumed;
    endfunction

endpackage

// File: rtl/li_token_slot.sv
// One incoming token slot: done flag, payload latch and CONSUMED generation.
// The slot takes one token per model cycle and ignores further tokens until
// the parent clears it on the commit edge.
module li_token_slot
    import li_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             valid,
    input  logic [WIDTH-1:0] payload,
    input  logic             clear,
    output logic             consumed,
    output logic             done,
    output logic [WIDTH-1:0] data
);

    logic             done_q;
    logic [WIDTH-1:0] data_q;
    logic             taken;

    // Only depends on our own VALID and flag, so no path from downstream.
    // Gated by RST_N so no token is swallowed while reset is held.
    assign consumed = RST_N && valid && !done_q;
    assign taken    = xfer(valid, consumed);

    // Views that already count a transfer happening on this clock, so the
    // parent can commit on the same edge as the final token.
    assign done = done_q || taken;
    assign data = taken ? payload : data_q;

    // Latch the first token of the model cycle; clear on commit.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            done_q <= 1'b0;
            data_q <= '0;
        end else if (clear) begin
            done_q <= 1'b0;
        end else if (taken) begin
            done_q <= 1'b1;
            data_q <= payload;
        end
    end

endmodule

// File: rtl/li_reg_port.sv
// Latency-insensitive register responder. Each model cycle it offers the
// current value as a read token, collects a write-data and write-enable
// token, then commits. The read token never waits on the write tokens,
// which lets parents close register loops without a combinational cycle.
module li_reg_port
    import li_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [WIDTH-1:0]    IN_WRITE,
    input  logic                IN_WRITE_VALID,
    output logic                IN_WRITE_CONSUMED,
    input  logic                IN_EN_WRITE,
    input  logic                IN_EN_WRITE_VALID,
    output logic                IN_EN_WRITE_CONSUMED,
    output logic [WIDTH-1:0]    OUT_READ,
    output logic                OUT_READ_VALID,
    input  logic                OUT_READ_CONSUMED,
    output logic [MC_WIDTH-1:0] MODEL_CYCLE
);

    // Flag vector {rd_done, wr_got, en_got}; every value other than
    // ST_ALL_DONE is a COLLECT state.
    localparam logic [2:0] ST_NONE_DONE = 3'b000;
    localparam logic [2:0] ST_ALL_DONE  = 3'b111;

    logic [WIDTH-1:0]    value_q;
    logic [MC_WIDTH-1:0] model_cycle_q;
    logic                rd_done_q;
    logic                read_valid_q;

    logic                rd_xfer;
    logic                rd_done;
    logic                wr_done;
    logic                en_done;
    logic [WIDTH-1:0]    wr_data;
    logic [0:0]          en_data;
    logic [2:0]          flags_next;
    logic                commit;

    li_token_slot #(.WIDTH(WIDTH)) u_wr_slot (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .valid    (IN_WRITE_VALID),
        .payload  (IN_WRITE),
        .clear    (commit),
        .consumed (IN_WRITE_CONSUMED),
        .done     (wr_done),
        .data     (wr_data)
    );

    li_token_slot #(.WIDTH(1)) u_en_slot (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .valid    (IN_EN_WRITE_VALID),
        .payload  (IN_EN_WRITE),
        .clear    (commit),
        .consumed (IN_EN_WRITE_CONSUMED),
        .done     (en_done),
        .data     (en_data)
    );

    assign rd_xfer    = xfer(read_valid_q, OUT_READ_CONSUMED);
    assign rd_done    = rd_done_q || rd_xfer;
    assign flags_next = {rd_done, wr_done, en_done};
    assign commit     = (flags_next == ST_ALL_DONE);

    assign OUT_READ       = value_q;
    assign OUT_READ_VALID = read_valid_q;
    assign MODEL_CYCLE    = model_cycle_q;

    // Read-side flag, registered read VALID, register value and counter.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rd_done_q     <= ST_NONE_DONE[2];
            read_valid_q  <= 1'b0;
            value_q       <= INIT;
            model_cycle_q <= '0;
        end else begin
            if (commit) begin
                rd_done_q <= 1'b0;
            end else if (rd_xfer) begin
                rd_done_q <= 1'b1;
            end
            // A fresh read token is offered right after every commit.
            read_valid_q <= commit || !rd_done;
            if (commit) begin
                if (en_data[0]) begin
                    value_q <= wr_data;
                end
                model_cycle_q <= model_cycle_q + MC_WIDTH'(1);
            end
        end
    end

endmodule
